// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Multi-cycle issue controller on the driving side of a 16-bit ALU. It accepts
// one instruction at a time, reads operands from an internal 8x16 register
// file, applies the optional B-operand shift, and presents registered operands
// and the opcode to the ALU. It captures the ALU result and {Z,N,V} status,
// writes back, and pulses done.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   instruction handshake (ready only while idle)
//   in_mov                1: write in_imm to rd, 0: ALU instruction
//   in_op                 ALU op: 00 add, 01 sub, 10 and, 11 not-B
//   in_wb                 1: write ALU result to rd, 0: status only
//   in_rd, in_rn, in_rm   destination, A source, B source register indices
//   in_shift              B shift: 00 none, 01 LSL1, 10 LSR1, 11 ASR1
//   in_imm                immediate for mov
//   alu_ain/alu_bin/alu_op  registered ALU inputs
//   alu_out, alu_status   ALU result and {Z,N,V}
//   result, status        last captured ALU result and {Z,N,V}
//   done                  one-cycle pulse when an instruction completes
//   dbg_addr / dbg_data   combinational register-file read port
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_issue_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mov,
    input  logic [1:0]        in_op,
    input  logic              in_wb,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rm,
    input  logic [1:0]        in_shift,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_ain,
    output logic [DATA_W-1:0] alu_bin,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        alu_status,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        status,
    output logic              done,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t            state_q, state_d;

    // Instruction fields captured at accept
    logic              mov_q, mov_d;
    logic [1:0]        op_q, op_d;
    logic              wb_q, wb_d;
    logic [2:0]        rd_q, rd_d;
    logic [2:0]        rn_q, rn_d;
    logic [2:0]        rm_q, rm_d;
    logic [1:0]        shift_q, shift_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    // Datapath registers
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [2:0]        status_q, status_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Registered handshake outputs
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;

    // B-operand shifter; LSR fills with zero, ASR replicates the sign bit.
    function automatic logic [DATA_W-1:0] shift_b(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        sh
    );
        logic [DATA_W-1:0] y;
        case (sh)
            2'b01:   y = {x[DATA_W-2:0], 1'b0};
            2'b10:   y = {1'b0, x[DATA_W-1:1]};
            2'b11:   y = {x[DATA_W-1], x[DATA_W-1:1]};
            default: y = x;
        endcase
        return y;
    endfunction

    always_comb begin
        state_d  = state_q;
        mov_d    = mov_q;
        op_d     = op_q;
        wb_d     = wb_q;
        rd_d     = rd_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        shift_d  = shift_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        status_d = status_q;
        regs_d   = regs_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mov_d   = in_mov;
                    op_d    = in_op;
                    wb_d    = in_wb;
                    rd_d    = in_rd;
                    rn_d    = in_rn;
                    rm_d    = in_rm;
                    shift_d = in_shift;
                    imm_d   = in_imm;
                    state_d = in_mov ? S_WRITE : S_RD_A;
                end
            end
            S_RD_A: begin
                a_d     = regs_q[rn_q];
                state_d = S_RD_B;
            end
            S_RD_B: begin
                b_d     = shift_b(regs_q[rm_q], shift_q);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // The ALU is only sampled here, after its inputs have been
                // stable for the whole cycle.
                c_d      = alu_out;
                status_d = alu_status;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                // Operands were read in earlier states, so rd aliasing rn/rm
                // naturally uses the old values.
                if (mov_q) begin
                    regs_d[rd_q] = imm_q;
                end else if (wb_q) begin
                    regs_d[rd_q] = c_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are registered, so derive them from the next state.
        in_ready_d = (state_d == S_IDLE);
        done_d     = (state_d == S_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mov_q      <= 1'b0;
            op_q       <= 2'b00;
            wb_q       <= 1'b0;
            rd_q       <= 3'd0;
            rn_q       <= 3'd0;
            rm_q       <= 3'd0;
            shift_q    <= 2'b00;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            status_q   <= 3'b000;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mov_q      <= mov_d;
            op_q       <= op_d;
            wb_q       <= wb_d;
            rd_q       <= rd_d;
            rn_q       <= rn_d;
            rm_q       <= rm_d;
            shift_q    <= shift_d;
            imm_q      <= imm_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            status_q   <= status_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign in_ready = in_ready_q;
    assign done     = done_q;
    assign alu_ain  = a_q;
    assign alu_bin  = b_q;
    assign alu_op   = op_q;
    assign result   = c_q;
    assign status   = status_q;
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
`timescale 1ns/1ps

module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_mov;
    logic [1:0]  in_op;
    logic        in_wb;
    logic [2:0]  in_rd, in_rn, in_rm;
    logic [1:0]  in_shift;
    logic [15:0] in_imm;
    logic [15:0] alu_ain, alu_bin;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic [2:0]  alu_status;
    logic [15:0] result;
    logic [2:0]  status;
    logic        done;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(16), .NREG(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mov     (in_mov),
        .in_op      (in_op),
        .in_wb      (in_wb),
        .in_rd      (in_rd),
        .in_rn      (in_rn),
        .in_rm      (in_rm),
        .in_shift   (in_shift),
        .in_imm     (in_imm),
        .alu_ain    (alu_ain),
        .alu_bin    (alu_bin),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_status (alu_status),
        .result     (result),
        .status     (status),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Behavioural 16-bit ALU driven by the controller
    always_comb begin
        alu_out    = 16'h0000;
        alu_status = 3'b000;
        case (alu_op)
            2'b00:   alu_out = alu_ain + alu_bin;
            2'b01:   alu_out = alu_ain - alu_bin;
            2'b10:   alu_out = alu_ain & alu_bin;
            default: alu_out = ~alu_bin;
        endcase
        alu_status[2] = (alu_out == 16'h0000);
        alu_status[1] = alu_out[15];
        if (alu_op == 2'b00)
            alu_status[0] = (alu_ain[15] == alu_bin[15]) && (alu_out[15] != alu_ain[15]);
        else if (alu_op == 2'b01)
            alu_status[0] = (alu_ain[15] != alu_bin[15]) && (alu_out[15] != alu_ain[15]);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: expected completion pushed at drive time, popped on done
    typedef struct {
        int          due;
        logic [15:0] res;
        logic [2:0]  st;
    } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.due);
                    chk("result", {16'h0, result}, {16'h0, e.res});
                    chk("status", {29'h0, status}, {29'h0, e.st});
                    chk("ready_in_done", {31'h0, in_ready}, 32'h0);
                end
            end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL done_timeout actual=none required=cycle_%0d", e.due);
            end
        end
    end

    typedef struct {
        logic        mov;
        logic [1:0]  op;
        logic        wb;
        logic [2:0]  rd, rn, rm;
        logic [1:0]  sh;
        logic [15:0] imm;
        logic [15:0] exp_b;
        logic [15:0] exp_res;
        logic [2:0]  exp_st;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] model [8];

    task automatic check_regs(input string name);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk(name, {16'h0, dbg_data}, {16'h0, model[r]});
        end
    endtask

    task automatic drive(input vec_t v);
        in_mov   = v.mov;
        in_op    = v.op;
        in_wb    = v.wb;
        in_rd    = v.rd;
        in_rn    = v.rn;
        in_rm    = v.rm;
        in_shift = v.sh;
        in_imm   = v.imm;
    endtask

    task automatic send(input vec_t v);
        int c;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        drive(v);
        in_valid = 1'b1;
        c = cyc;
        sbq.push_back('{due: c + (v.mov ? 1 : 4), res: v.exp_res, st: v.exp_st});
        @(negedge clk);
        in_valid = 1'b0;
        // Run until one cycle past the done cycle so the write has landed
        while (cyc < c + (v.mov ? 2 : 5)) begin
            if (!v.mov && cyc == c + 3) begin
                chk("exec_bin", {16'h0, alu_bin}, {16'h0, v.exp_b});
                chk("exec_op", {30'h0, alu_op}, {30'h0, v.op});
            end
            @(negedge clk);
        end
        if (v.mov)
            model[v.rd] = v.imm;
        else if (v.wb)
            model[v.rd] = v.exp_res;
        check_regs("dbg_reg");
    endtask

    initial begin
        int c;
        int acc;
        vec_t hv;

        //          mov  op     wb    rd    rn    rm    sh     imm       exp_b     exp_res   st
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0007, 16'h0000, 16'h0000, 3'b000};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 3'd1, 3'd0, 3'd0, 2'b00, 16'h0002, 16'h0000, 16'h0000, 3'b000};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'd2, 3'd0, 3'd1, 2'b01, 16'h0000, 16'h0004, 16'h000B, 3'b000};
        vecs[3]  = '{1'b0, 2'b01, 1'b0, 3'd7, 3'd1, 3'd0, 2'b00, 16'h0000, 16'h0007, 16'hFFFB, 3'b010};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 3'd3, 3'd0, 3'd0, 2'b00, 16'h7FFF, 16'h0000, 16'hFFFB, 3'b010};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 3'd4, 3'd3, 3'd3, 2'b00, 16'h0000, 16'h7FFF, 16'hFFFE, 3'b011};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 3'd5, 3'd0, 3'd0, 2'b00, 16'h8002, 16'h0000, 16'hFFFE, 3'b011};
        vecs[7]  = '{1'b0, 2'b11, 1'b1, 3'd5, 3'd0, 3'd5, 2'b11, 16'h0000, 16'hC001, 16'h3FFE, 3'b000};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0001, 16'h0000, 16'h3FFE, 3'b000};
        vecs[9]  = '{1'b0, 2'b10, 1'b1, 3'd6, 3'd0, 3'd1, 2'b00, 16'h0000, 16'h0002, 16'h0000, 3'b100};
        vecs[10] = '{1'b0, 2'b01, 1'b1, 3'd7, 3'd3, 3'd5, 2'b10, 16'h0000, 16'h1FFF, 16'h6000, 3'b000};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 3'd2, 3'd2, 3'd2, 2'b00, 16'h0000, 16'h000B, 16'h0016, 3'b000};

        for (int r = 0; r < 8; r++) model[r] = 16'h0000;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        drive(vecs[0]);
        dbg_addr = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_status", {29'h0, status}, 32'h0);
        chk("rst_alu_op", {30'h0, alu_op}, 32'h0);
        check_regs("rst_reg");
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) send(vecs[i]);

        // in_valid held across busy periods: one accept per IDLE visit
        hv = '{1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 16'h0000, 16'h0001, 16'h0002, 3'b000};
        @(negedge clk);
        drive(hv);
        in_valid = 1'b1;
        c = cyc;
        sbq.push_back('{due: c + 4, res: 16'h0002, st: 3'b000});
        sbq.push_back('{due: c + 9, res: 16'h0002, st: 3'b000});
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("held_accepts", acc, 2);
        @(negedge clk);
        check_regs("held_reg");

        // Reset while in EXEC: everything clears, no done, no write
        @(negedge clk);
        hv = '{1'b0, 2'b00, 1'b1, 3'd1, 3'd0, 3'd1, 2'b00, 16'h0000, 16'h0002, 16'h0003, 3'b000};
        drive(hv);
        in_valid = 1'b1;
        c = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        while (cyc < c + 3) @(negedge clk);
        chk("pre_rst_ain", {16'h0, alu_ain}, 32'h0001);
        reset_n = 1'b0;
        #1;
        chk("arst_ready", {31'h0, in_ready}, 32'h1);
        chk("arst_done", {31'h0, done}, 32'h0);
        chk("arst_status", {29'h0, status}, 32'h0);
        chk("arst_result", {16'h0, result}, 32'h0);
        chk("arst_ain", {16'h0, alu_ain}, 32'h0);
        chk("arst_bin", {16'h0, alu_bin}, 32'h0);
        for (int r = 0; r < 8; r++) model[r] = 16'h0000;
        check_regs("arst_reg");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
        check_regs("post_rst_reg");
        chk("sb_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits on the driving side of the 16-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8×16 register file. It applies the optional Bin shift, drives the ALU's Ain/Bin/ALUop inputs, and captures the ALU result and {Z,N,V} status. It then writes the result back and pulses done.

## Interface
- DATA_W, 16, datapath width (ALU width; fixed at 16 for this design)
- NREG, 8, register-file depth; register index width is 3 bits
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous reset, active low
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept (high only in IDLE)
- in_mov  in  1  1: write in_imm to rd (no ALU); 0: ALU instruction
- in_op  in  2  ALUop: 00 add, 01 sub, 10 and, 11 not-Bin
- in_wb  in  1  1: write result to rd; 0: status only (compare)
- in_rd, in_rn, in_rm  in  3 each  destination, A source, B source
- in_shift  in  2  Bin shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- in_imm  in  16  immediate for in_mov
- alu_ain, alu_bin  out  16  ALU operands (registered A, B)
- alu_op  out  2  ALUop (registered)
- alu_out  in  16  ALU result (combinational from alu_* outputs)
- alu_status  in  3  {Z,N,V} from ALU
- result  out  16  C register, last ALU result
- status  out  3  registered {Z,N,V}
- done  out  1  one-cycle pulse on instruction completion
- dbg_addr  in  3  debug read index
- dbg_data  out  16  combinational R[dbg_addr]

## Operation
- States: IDLE, RD_A, RD_B, EXEC, WRITE.
- IDLE: in_ready=1. On in_valid, latch op, wb, rd, rn, rm, shift, and imm.
  - in_mov=1: go to WRITE.
  - in_mov=0: go to RD_A.
- RD_A: A ← R[rn]. Go to RD_B.
- RD_B: B ← shift(R[rm]). Go to EXEC.
  - LSL1: {x[14:0],0}. LSR1: {0,x[15:1]}. ASR1: {x[15],x[15:1]}.
- EXEC: alu_ain=A, alu_bin=B, alu_op=op.
  - At the clock edge ending the cycle: C ← alu_out, status ← alu_status.
  - Go to WRITE.
- WRITE: done=1.
  - mov: R[rd] ← imm. status and C are unchanged.
  - ALU with wb=1: R[rd] ← C.
  - ALU with wb=0: no register write.
  - Go to IDLE.
- rd may equal rn or rm. Operands are read before the write, so the old values are used.
- Inputs are ignored outside IDLE; in_valid held while busy has no effect.
- ALU outputs hold their registered values in all states. The ALU is never sampled outside EXEC.
- Result width is 16 bits; there is no carry out. Overflow is reported only via alu_status V.

## Timing
- Reset (async, reset_n=0): state=IDLE, all R[i]=0, A=B=C=0, status=000, done=0, alu_op=00, in_ready=1 once state is IDLE.
- Reset mid-operation aborts immediately; no partial write is retained.
- ALU instruction accepted at edge k: RD_A in cycle k+1, EXEC in cycle k+3, done high in cycle k+4. The register write lands at edge k+5, when in_ready returns to 1.
- mov accepted at edge k: done in cycle k+1, write at edge k+2.
- Throughput: one ALU instruction per 5 cycles, one mov per 2 cycles.
- in_ready is 0 during the done cycle. The next accept is at the earliest IDLE cycle.
- status changes only at the end of EXEC. result changes only at the end of EXEC.
- dbg_data reflects a write from the cycle after the write edge.

## Test plan
- mov R0=7, mov R1=2, then add R2=R0+(R1 LSL1), wb=1:
  - done 4 cycles after accept
  - R2=0x000B, result=0x000B, status=000
- Compare sub R1−R0 (2−7), wb=0:
  - result=0xFFFB, status=010
  - R0..R7 unchanged
- mov R3=0x7FFF, then add R4=R3+R3:
  - R4=0xFFFE, status=011
- mov R5=0x8002, then not-Bin with rm=R5, shift ASR1, rd=R5:
  - B=0xC001, R5=0x3FFE, status=000
- and R6=R0&R1 with R0=1, R1=2:
  - R6=0, status=100
- Holding in_valid through a busy period gets exactly one accept per IDLE visit.
- Dropping reset_n in EXEC:
  - all registers read 0, status=000, in_ready=1, no done pulse.
